// File: rtl/aes_pkg.sv
// aes_pkg: shared widths, word counts and loader state type for the AES word loader
package aes_pkg;
  localparam int key_words_gp = 8;
  localparam int text_words_gp = 4;
  localparam int aes_key_width_gp = 256;
  localparam int aes_block_width_gp = 128;
  typedef enum logic [1:0] {eLoad, eSettle, eOut} aes_loader_state_e;
endpackage

// File: rtl/aes_word_loader.sv
// aes_word_loader: deserializes key/text words for a combinational AES core, settles, captures and hands off ciphertext
module aes_word_loader
  import aes_pkg::*;
#(
  parameter int word_width_p = 32,
  parameter int settle_cycles_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [word_width_p-1:0]       data_i,
  input  logic                          key_i,
  input  logic                          v_i,
  output logic                          ready_o,
  output logic [aes_key_width_gp-1:0]   key_o,
  output logic [aes_block_width_gp-1:0] plaintext_o,
  input  logic [aes_block_width_gp-1:0] ciphertext_i,
  output logic [aes_block_width_gp-1:0] data_o,
  output logic                          v_o,
  input  logic                          yumi_i
);
  localparam int sw = settle_cycles_p > 1 ? $clog2(settle_cycles_p) : 1;
  aes_loader_state_e r_state;
  logic [2:0] r_kcnt;
  logic [1:0] r_tcnt;
  logic [sw-1:0] r_scnt;
  logic r_loaded, r_v;
  logic [aes_key_width_gp-1:0] r_key;
  logic [aes_block_width_gp-1:0] r_text, r_data;
  logic w_key_acc, w_text_acc, w_key_last, w_text_last;
  assign ready_o = (r_state == eLoad) & (key_i | r_loaded);
  assign w_key_acc = v_i & ready_o & key_i;
  assign w_text_acc = v_i & ready_o & ~key_i;
  assign w_key_last = r_kcnt == 3'(key_words_gp - 1);
  assign w_text_last = r_tcnt == 2'(text_words_gp - 1);
  assign key_o = r_key;
  assign plaintext_o = r_text;
  assign data_o = r_data;
  assign v_o = r_v;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= eLoad;
      r_kcnt <= '0;
      r_tcnt <= '0;
      r_scnt <= '0;
      r_loaded <= 1'b0;
      r_v <= 1'b0;
      r_key <= '0;
      r_text <= '0;
      r_data <= '0;
    end else begin
      if (w_key_acc) begin
        r_key <= {r_key[aes_key_width_gp-word_width_p-1:0], data_i};
        r_kcnt <= w_key_last ? '0 : r_kcnt + 3'd1;
        r_loaded <= w_key_last;
      end
      if (w_text_acc) begin
        r_text <= {r_text[aes_block_width_gp-word_width_p-1:0], data_i};
        r_tcnt <= w_text_last ? '0 : r_tcnt + 2'd1;
        if (w_text_last) begin
          r_state <= eSettle;
          r_scnt <= sw'(settle_cycles_p - 1);
        end
      end
      if (r_state == eSettle) begin
        r_scnt <= r_scnt - sw'(1);
        if (r_scnt == '0) begin
          r_data <= ciphertext_i;
          r_v <= 1'b1;
          r_state <= eOut;
        end
      end
      if (r_state == eOut && yumi_i) begin
        r_v <= 1'b0;
        r_state <= eLoad;
      end
    end
  end
endmodule
